readout_spi_tx: RTL
===================

Name: readout_spi_tx

Overview:
- Downstream consumer of the multi-channel digitizer readout.
- While the digitizer holds ZYNQ_RD_EN high, this block serializes its 16-bit DOUT words to the ZYNQ over an SPI-master link generated from SYSCLK.
- Each event is framed as header, event number, data words, then trailer.
- Pulses SPI_done once per data word shifted, which advances the digitizer to its next sample/channel.

Parameters:
- DATA_WIDTH, 16, word width of DIN and of every SPI word.
- CLK_DIV, 2, SYSCLK cycles per SCLK half-period; legal range 1..255.
- HDR_WORD, 16'hA5A5, first word of every event frame.
- TRL_WORD, 16'h5A5A, last word of every event frame.

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- RST_n  in  1  asynchronous active-low reset.
- ZYNQ_RD_EN  in  1  readout-active level from digitizer.
- DIN  in  DATA_WIDTH  current data word (digitizer DOUT).
- SPI_done  out  1  one-SYSCLK pulse per completed data word.
- SCLK  out  1  SPI clock, mode 0 (idle low).
- MOSI  out  1  SPI data, MSB first.
- CS_n  out  1  SPI chip select, low for the whole event frame.
- busy  out  1  high in any state other than IDLE.
- evt_count  out  16  number of completed frames; wraps 0xFFFF->0.
- word_count  out  16  data words in the last completed frame; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release): state=IDLE, SCLK=0, MOSI=0, CS_n=1, SPI_done=0, busy=0, evt_count=0, word_count=0, armed=1. Reset mid-frame aborts the frame immediately, with no trailer and no count update.
- States and transitions:
  - IDLE -> LOAD when ZYNQ_RD_EN=1 and armed=1.
  - LOAD: one cycle; loads shift register and drives MOSI=bit15; -> SHIFT.
  - SHIFT -> LOAD for the next word, or -> GAP after the trailer.
  - GAP: CS_n=1 for 2*CLK_DIV cycles; -> IDLE.
- armed: cleared on leaving IDLE; set whenever ZYNQ_RD_EN is sampled 0. A level still high after a frame never restarts a frame.
- Word sequence per frame, tracked in a 2-bit word-type register:
  - HDR_WORD.
  - evt_count value, pre-increment.
  - DATA words, repeated.
  - TRL_WORD.
- DATA words: DIN is captured in LOAD only.
- After the event-number word:
  - If ZYNQ_RD_EN=1, the next word is DATA.
  - If ZYNQ_RD_EN=0, the next word is the trailer, giving a zero-data frame.
- After each DATA word: next word is DATA if ZYNQ_RD_EN=1 in the LOAD cycle decision, else the trailer.
- ZYNQ_RD_EN falling mid-word: the current word completes fully and SPI_done is still pulsed for it.
- CS_n goes low in the first LOAD cycle and high on entry to GAP.
- SHIFT timing:
  - Per bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - MOSI changes only at the high->low SCLK transition, shifting the next bit.
  - After bit 0's high phase, SCLK returns low and the word ends.
- Word time is 1 + 2*CLK_DIV*DATA_WIDTH SYSCLK cycles.
- SPI_done: single-cycle pulse in the cycle a DATA word ends; never pulsed for header, event-number or trailer words. The next LOAD happens one cycle after the pulse, so the digitizer has one cycle to update DIN.
- Counters:
  - Internal data-word counter increments per DATA word and saturates at 0xFFFF.
  - On GAP entry: word_count <= data-word counter, evt_count <= evt_count+1.
  - The data-word counter clears in the first LOAD of a frame.
- busy=1 from the first LOAD through the last GAP cycle.

Test Plan:
- Reset with ZYNQ_RD_EN=0 -> CS_n=1, SCLK=0, MOSI=0, busy=0, evt_count=0, word_count=0. Pulse RST_n low mid-frame -> outputs return to these values within the same cycle.
- CLK_DIV=2; raise ZYNQ_RD_EN, hold DIN=16'h1230, drop ZYNQ_RD_EN after 3 SPI_done pulses. Required:
  - MOSI sampled on SCLK rising edges gives A5A5, 0000, 1230, 1230, 1230, 5A5A.
  - Exactly 3 SPI_done pulses, 65 cycles apart.
  - word_count=3, evt_count=1.
- ZYNQ_RD_EN drops at bit 7 of the first data word -> word completes, one SPI_done, trailer follows; word_count=1.
- ZYNQ_RD_EN held high continuously after a frame ends -> no second frame. Drop it for 1 cycle and raise -> second frame with event-number word 0001.
- ZYNQ_RD_EN drops during the event-number word -> frame is A5A5, evt, 5A5A; zero SPI_done pulses; word_count=0.
- CLK_DIV=1 -> SCLK period 2 cycles, word time 33 cycles; GAP holds CS_n high for exactly 2 cycles before the next frame's CS_n low.

Source files
------------

// File: rtl/readout_spi_tx_if.sv
// Digitizer-to-SPI readout link bundle: digitizer handshake, SPI pins and frame status.
// The transmitter uses the master modport. The digitizer or bench uses the slave modport.
interface readout_spi_tx_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  ZYNQ_RD_EN;
    logic [DATA_WIDTH-1:0] DIN;
    logic                  SPI_done;
    logic                  SCLK;
    logic                  MOSI;
    logic                  CS_n;
    logic                  busy;
    logic [15:0]           evt_count;
    logic [15:0]           word_count;

    modport master (
        input  ZYNQ_RD_EN, DIN,
        output SPI_done, SCLK, MOSI, CS_n, busy, evt_count, word_count
    );

    modport slave (
        output ZYNQ_RD_EN, DIN,
        input  SPI_done, SCLK, MOSI, CS_n, busy, evt_count, word_count
    );
endinterface

// File: rtl/readout_spi_tx.sv
// Frames digitizer readout into SPI words (header, event number, data..., trailer), mode 0, MSB first.
// SCLK is divided from SYSCLK. SPI_done requests the next DIN word one cycle before it is loaded.
module readout_spi_tx #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    CLK_DIV    = 2,
    parameter logic [DATA_WIDTH-1:0] HDR_WORD   = 16'hA5A5,
    parameter logic [DATA_WIDTH-1:0] TRL_WORD   = 16'h5A5A
) (
    input  logic               SYSCLK,
    input  logic               RST_n,
    readout_spi_tx_if.master   bus
);
    localparam int        BW       = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam bit         DIV1     = (CLK_DIV == 1);
    localparam logic [7:0] DIV_PRE  = DIV1 ? 8'd0 : 8'(CLK_DIV - 2);
    localparam logic [8:0] GAP_LAST = 9'(2 * CLK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;
    typedef enum logic [1:0] {W_HDR, W_EVT, W_DATA, W_TRL} wtype_t;

    state_t                state;
    wtype_t                wtype;
    wtype_t                nxt_type;
    logic [DATA_WIDTH-1:0] nxt_word;
    logic [DATA_WIDTH-1:0] sreg;
    logic [BW-1:0]         bit_cnt;
    logic [7:0]            div_cnt;
    logic [8:0]            gap_cnt;
    logic                  sclk_q;
    logic                  mosi_q;
    logic                  cs_n_q;
    logic                  done_q;
    logic                  busy_q;
    logic                  armed;
    logic [15:0]           evt_q;
    logic [15:0]           wc_q;
    logic [15:0]           dcnt;
    logic                  last_bit;
    logic                  pre_end;

    assign bus.SCLK       = sclk_q;
    assign bus.MOSI       = mosi_q;
    assign bus.CS_n       = cs_n_q;
    assign bus.SPI_done   = done_q;
    assign bus.busy       = busy_q;
    assign bus.evt_count  = evt_q;
    assign bus.word_count = wc_q;

    assign last_bit = (bit_cnt == BIT_LAST);
    // High in the SHIFT cycle just before the word's final cycle. This registers SPI_done into that final cycle.
    assign pre_end  = last_bit && (DIV1 ? !sclk_q : (sclk_q && (div_cnt == DIV_PRE)));

    // wtype rests at W_TRL between frames, so the word after a trailer is always a header.
    always_comb begin
        nxt_type = W_HDR;
        case (wtype)
            W_TRL:          nxt_type = W_HDR;
            W_HDR:          nxt_type = W_EVT;
            W_EVT, W_DATA:  nxt_type = bus.ZYNQ_RD_EN ? W_DATA : W_TRL;
            default:        nxt_type = W_HDR;
        endcase
    end

    always_comb begin
        nxt_word = '0;
        case (nxt_type)
            W_HDR:   nxt_word = HDR_WORD;
            W_EVT:   nxt_word = DATA_WIDTH'(evt_q);
            W_DATA:  nxt_word = bus.DIN;
            W_TRL:   nxt_word = TRL_WORD;
            default: nxt_word = '0;
        endcase
    end

    always_ff @(posedge SYSCLK or negedge RST_n) begin
        if (!RST_n) begin
            state   <= S_IDLE;
            wtype   <= W_TRL;
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            armed   <= 1'b1;
            evt_q   <= '0;
            wc_q    <= '0;
            dcnt    <= '0;
        end else begin
            done_q <= 1'b0;
            if (!bus.ZYNQ_RD_EN) armed <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.ZYNQ_RD_EN && armed) begin
                        state  <= S_LOAD;
                        armed  <= 1'b0;
                        cs_n_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    wtype   <= nxt_type;
                    sreg    <= nxt_word;
                    mosi_q  <= nxt_word[DATA_WIDTH-1];
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    sclk_q  <= 1'b0;
                    state   <= S_SHIFT;
                    if (wtype == W_TRL) dcnt <= '0;
                end
                S_SHIFT: begin
                    if (pre_end && (wtype == W_DATA)) begin
                        done_q <= 1'b1;
                        if (dcnt != '1) dcnt <= dcnt + 16'd1;
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (last_bit) begin
                                if (wtype == W_TRL) begin
                                    state   <= S_GAP;
                                    cs_n_q  <= 1'b1;
                                    mosi_q  <= 1'b0;
                                    gap_cnt <= '0;
                                    wc_q    <= dcnt;
                                    evt_q   <= evt_q + 16'd1;
                                    // A level still high at frame end must not start another frame.
                                    armed   <= 1'b0;
                                end else begin
                                    state <= S_LOAD;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                sreg    <= {sreg[DATA_WIDTH-2:0], 1'b0};
                                mosi_q  <= sreg[DATA_WIDTH-2];
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 9'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
